// File: rtl/mcu_debug_responder_pkg.sv
// Shared types for the MCU-side debug responder.
//   resp_state_t : responder FSM states
//   dbg_cmd_t    : command selected from the incoming strobes
//   BE_WORD/BE_NONE : byte-enable constants
//   cmd_decode   : fixed-priority strobe encoder
//   be_is_byte   : true when exactly one byte lane is enabled
package dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE_WAIT,
    S_RESUME,
    S_RESET_PULSE,
    S_MEM_ACCESS,
    S_RF_ACCESS,
    S_NOP,
    S_REJECT
  } resp_state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_PAUSE,
    CMD_RESUME,
    CMD_RESET,
    CMD_MEM_RD,
    CMD_MEM_WR,
    CMD_RF_RD,
    CMD_RF_WR
  } dbg_cmd_t;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // reset > pause > resume > mem_wr > mem_rd > rf_wr > rf_rd
  function automatic dbg_cmd_t cmd_decode(
    input logic reset,
    input logic pause,
    input logic resume,
    input logic mem_wr,
    input logic mem_rd,
    input logic rf_wr,
    input logic rf_rd
  );
    if (reset)       return CMD_RESET;
    else if (pause)  return CMD_PAUSE;
    else if (resume) return CMD_RESUME;
    else if (mem_wr) return CMD_MEM_WR;
    else if (mem_rd) return CMD_MEM_RD;
    else if (rf_wr)  return CMD_RF_WR;
    else if (rf_rd)  return CMD_RF_RD;
    else             return CMD_NONE;
  endfunction

  function automatic logic be_is_byte(input logic [3:0] be);
    return (be == 4'b0001) || (be == 4'b0010) ||
           (be == 4'b0100) || (be == 4'b1000);
  endfunction

endpackage

// File: rtl/mcu_debug_responder_byte_extract.sv
// dbg_byte_extract: selects the byte lane named by a one-hot byte enable and
// zero-extends it to 32 bits. Non-one-hot enables yield zero.
//   be        in  4   byte enable (one-hot for a byte read)
//   data      in  32  memory read word
//   byte_data out 32  selected byte, zero-extended
module dbg_byte_extract
  import dbg_pkg::*;
(
  input  logic [3:0]  be,
  input  logic [31:0] data,
  output logic [31:0] byte_data
);

  always_comb begin
    byte_data = '0;
    case (be)
      4'b0001: byte_data = {24'd0, data[7:0]};
      4'b0010: byte_data = {24'd0, data[15:8]};
      4'b0100: byte_data = {24'd0, data[23:16]};
      4'b1000: byte_data = {24'd0, data[31:24]};
      default: byte_data = '0;
    endcase
  end

endmodule

// File: rtl/mcu_debug_responder.sv
// mcu_debug_responder: executes debugger commands (pause, resume, core reset,
// register and memory access) on the MCU core by stalling it, pulsing its
// reset, or borrowing its memory / register-file ports.
//
// Optional build macro DBG_RESP_WATCHDOG_EN: bounds the pause handshake to
// WDOG_CYCLES cycles; on expiry the core is force-stalled and err is set.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid + strobes       pause/resume/reset/rf_rd/rf_wr/mem_rd/mem_wr
//   mem_be, addr, wdata      command operands (addr[4:0] = register index)
//   mcu_busy, rd_data        busy flag and read result
//   paused, err              core-held flag, sticky rejection flag
//   core_idle/stall/reset    core handshake and control
//   dbg_mem_*, mem_rdata     memory port override
//   dbg_rf_*, rf_rdata       register-file port override
module mcu_debug_responder
  import dbg_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT   = 2,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned WDOG_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        pause,
  input  logic        resume,
  input  logic        reset,
  input  logic        rf_rd,
  input  logic        rf_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [3:0]  mem_be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mcu_busy,
  output logic [31:0] rd_data,
  output logic        paused,
  output logic        err,
  input  logic        core_idle,
  output logic        core_stall,
  output logic        core_reset,
  output logic        dbg_mem_en,
  output logic        dbg_mem_we,
  output logic [3:0]  dbg_mem_be,
  output logic [31:0] dbg_mem_addr,
  output logic [31:0] dbg_mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        dbg_rf_en,
  output logic        dbg_rf_we,
  output logic [4:0]  dbg_rf_addr,
  output logic [31:0] dbg_rf_wdata,
  input  logic [31:0] rf_rdata
);

  localparam logic [15:0] LAT_LAST  = 16'(MEM_RD_LAT);
  localparam logic [15:0] RST_LAST  = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
`ifdef DBG_RESP_WATCHDOG_EN
  localparam logic WDOG_EN = 1'b1;
`else
  localparam logic WDOG_EN = 1'b0;
`endif

  resp_state_t state, state_next;
  dbg_cmd_t    cmd, op_cmd;
  logic [31:0] op_addr, op_wdata;
  logic [3:0]  op_be;
  logic [15:0] cnt;
  logic        paused_q, stall_q, err_q;
  logic [31:0] rd_data_q;
  logic [31:0] byte_data;
  logic        be_ok, accept, wdog_hit;
  logic [4:0]  rf_idx;

  assign cmd      = cmd_decode(reset, pause, resume, mem_wr, mem_rd, rf_wr, rf_rd);
  assign be_ok    = (mem_be == BE_WORD) || be_is_byte(mem_be);
  assign accept   = (state == S_IDLE) && in_valid && (cmd != CMD_NONE);
  assign wdog_hit = WDOG_EN && (cnt == WDOG_LAST);
  assign rf_idx   = op_addr[4:0];

  dbg_byte_extract u_byte_extract (
    .be        (op_be),
    .data      (mem_rdata),
    .byte_data (byte_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mcu_busy   = (state != S_IDLE);
    core_reset = 1'b0;
    dbg_mem_en = 1'b0;
    dbg_rf_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          case (cmd)
            CMD_RESET:  state_next = S_RESET_PULSE;
            CMD_PAUSE:  state_next = paused_q ? S_NOP : S_PAUSE_WAIT;
            CMD_RESUME: state_next = S_RESUME;
            CMD_MEM_RD,
            CMD_MEM_WR: state_next = (paused_q && be_ok) ? S_MEM_ACCESS : S_REJECT;
            CMD_RF_RD,
            CMD_RF_WR:  state_next = paused_q ? S_RF_ACCESS : S_REJECT;
            default:    state_next = S_IDLE;
          endcase
        end
      end
      S_PAUSE_WAIT: if (core_idle || wdog_hit) state_next = S_IDLE;
      S_RESET_PULSE: begin
        core_reset = 1'b1;
        if (cnt == RST_LAST) state_next = S_IDLE;
      end
      S_MEM_ACCESS: begin
        dbg_mem_en = 1'b1;
        // writes complete in their single we cycle; reads wait out the latency
        if ((op_cmd != CMD_MEM_RD) || (cnt == LAT_LAST)) state_next = S_IDLE;
      end
      S_RF_ACCESS: begin
        dbg_rf_en  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    dbg_mem_we    = dbg_mem_en && (op_cmd == CMD_MEM_WR);
    dbg_mem_be    = dbg_mem_en ? op_be : BE_NONE;
    dbg_mem_addr  = dbg_mem_en ? op_addr : '0;
    dbg_mem_wdata = dbg_mem_en ? op_wdata : '0;
    // x0 is hardwired: the port is still borrowed but nothing is written
    dbg_rf_we     = dbg_rf_en && (op_cmd == CMD_RF_WR) && (rf_idx != 5'd0);
    dbg_rf_addr   = dbg_rf_en ? rf_idx : '0;
    dbg_rf_wdata  = dbg_rf_en ? op_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_cmd    <= CMD_NONE;
      op_addr   <= '0;
      op_wdata  <= '0;
      op_be     <= '0;
      cnt       <= '0;
      paused_q  <= 1'b0;
      stall_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_cmd   <= cmd;
            op_addr  <= addr;
            op_wdata <= wdata;
            op_be    <= mem_be;
            cnt      <= '0;
            if (state_next != S_REJECT) err_q <= 1'b0;
          end
        end
        S_PAUSE_WAIT: begin
          cnt <= cnt + 16'd1;
          if (core_idle) begin
            stall_q  <= 1'b1;
            paused_q <= 1'b1;
          end else if (wdog_hit) begin
            stall_q  <= 1'b1;
            paused_q <= 1'b1;
            err_q    <= 1'b1;
          end
        end
        S_RESUME: begin
          stall_q  <= 1'b0;
          paused_q <= 1'b0;
        end
        S_RESET_PULSE: cnt <= cnt + 16'd1;
        S_MEM_ACCESS: begin
          cnt <= cnt + 16'd1;
          if ((op_cmd == CMD_MEM_RD) && (cnt == LAT_LAST))
            rd_data_q <= be_is_byte(op_be) ? byte_data : mem_rdata;
        end
        S_RF_ACCESS: begin
          if (op_cmd == CMD_RF_RD)
            rd_data_q <= (rf_idx == 5'd0) ? '0 : rf_rdata;
        end
        S_REJECT: err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_data    = rd_data_q;
  assign paused     = paused_q;
  assign err        = err_q;
  assign core_stall = stall_q;

endmodule

// File: tb/tb_mcu_debug_responder.sv
module tb_mcu_debug_responder;

  localparam int MEM_LAT = 2;
  localparam int RST_CYC = 4;
  localparam int BOUND   = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        pause = 1'b0, resume = 1'b0, reset = 1'b0;
  logic        rf_rd = 1'b0, rf_wr = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [3:0]  mem_be = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        core_idle = 1'b0;
  logic        mcu_busy, paused, err, core_stall, core_reset;
  logic [31:0] rd_data;
  logic        dbg_mem_en, dbg_mem_we, dbg_rf_en, dbg_rf_we;
  logic [3:0]  dbg_mem_be;
  logic [31:0] dbg_mem_addr, dbg_mem_wdata, dbg_rf_wdata;
  logic [4:0]  dbg_rf_addr;
  logic [31:0] mem_rdata, rf_rdata;

  int total = 0;
  int bad   = 0;

  // reference state
  logic        m_paused = 1'b0;
  logic        m_err    = 1'b0;
  logic [31:0] m_rd     = '0;

  // memory / register-file models
  logic [31:0] mem_word = 32'h0;
  logic [31:0] rf_val   = 32'h0;
  int          en_age   = 0;
  assign mem_rdata = (dbg_mem_en && en_age == MEM_LAT) ? mem_word : 32'hDEAD_BEEF;
  assign rf_rdata  = rf_val;

  // activity monitors
  int          pulse_cnt = 0, mem_en_cnt = 0, rf_we_cnt = 0;
  logic [4:0]  rf_we_addr = '0;
  logic [31:0] rf_we_data = '0;

  mcu_debug_responder #(.MEM_RD_LAT(MEM_LAT), .RESET_CYCLES(RST_CYC), .WDOG_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pause(pause), .resume(resume),
    .reset(reset), .rf_rd(rf_rd), .rf_wr(rf_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_be(mem_be), .addr(addr), .wdata(wdata), .mcu_busy(mcu_busy),
    .rd_data(rd_data), .paused(paused), .err(err), .core_idle(core_idle),
    .core_stall(core_stall), .core_reset(core_reset), .dbg_mem_en(dbg_mem_en),
    .dbg_mem_we(dbg_mem_we), .dbg_mem_be(dbg_mem_be), .dbg_mem_addr(dbg_mem_addr),
    .dbg_mem_wdata(dbg_mem_wdata), .mem_rdata(mem_rdata), .dbg_rf_en(dbg_rf_en),
    .dbg_rf_we(dbg_rf_we), .dbg_rf_addr(dbg_rf_addr), .dbg_rf_wdata(dbg_rf_wdata),
    .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) en_age <= dbg_mem_en ? en_age + 1 : 0;

  always @(negedge clk) begin
    if (core_reset) pulse_cnt++;
    if (dbg_mem_en) mem_en_cnt++;
    if (dbg_rf_we) begin
      rf_we_cnt++;
      rf_we_addr = dbg_rf_addr;
      rf_we_data = dbg_rf_wdata;
    end
  end

  function automatic logic [31:0] pick_byte(input logic [31:0] w, input logic [3:0] be);
    for (int i = 0; i < 4; i++)
      if (be == (4'b0001 << i)) return (w >> (8 * i)) & 32'hFF;
    return w;
  endfunction

  function automatic logic be_legal(input logic [3:0] be);
    int ones = 0;
    for (int i = 0; i < 4; i++) ones += be[i];
    return (ones == 1) || (ones == 4);
  endfunction

  // stb = {reset, pause, resume, mem_wr, mem_rd, rf_wr, rf_rd}
  task automatic issue(input logic [6:0] stb, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, input int idle_delay, output int n);
    {reset, pause, resume, mem_wr, mem_rd, rf_wr, rf_rd} = stb;
    mem_be = be; addr = a; wdata = wd; in_valid = 1'b1;
    core_idle = (idle_delay == 0);
    pulse_cnt = 0; mem_en_cnt = 0; rf_we_cnt = 0;
    @(posedge clk); #1;
    {reset, pause, resume, mem_wr, mem_rd, rf_wr, rf_rd} = 7'($urandom);
    mem_be = 4'($urandom); addr = $urandom; wdata = $urandom;
    n = 0;
    while (mcu_busy && n < BOUND) begin
      core_idle = (n >= idle_delay);
      in_valid  = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (n >= BOUND) begin
      total++; bad++;
      $display("FAIL busy_timeout: busy still high after %0d cycles, required low", n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({mcu_busy, rd_data, paused, err, core_stall, core_reset, dbg_mem_en, dbg_mem_we,
         dbg_mem_be, dbg_mem_addr, dbg_mem_wdata, dbg_rf_en, dbg_rf_we, dbg_rf_addr,
         dbg_rf_wdata} !== 146'd0) begin
      bad++; $display("FAIL reset_outputs: got busy=%b rd=%h paused=%b err=%b stall=%b, required all zero",
                      mcu_busy, rd_data, paused, err, core_stall);
    end
    rst = 1'b0;
    m_paused = 1'b0; m_err = 1'b0; m_rd = '0;
  endtask

  task automatic test_no_strobe();
    int n;
    issue(7'b0, 4'hF, 32'h0, 32'h0, 0, n);
    total++;
    if (n !== 0) begin bad++; $display("FAIL no_strobe_busy: got %0d busy cycles, required 0", n); end
  endtask

  task automatic test_pause_handshake();
    int n;
    issue(7'b0100000, 4'h0, 32'h0, 32'h0, 5, n);
    m_paused = 1'b1;
    total++;
    if (n !== 6) begin bad++; $display("FAIL pause_busy: got %0d, required 6", n); end
    total++;
    if ({core_stall, paused} !== 2'b11) begin
      bad++; $display("FAIL pause_state: got stall=%b paused=%b, required 1 1", core_stall, paused);
    end
  endtask

  task automatic test_mem_byte_read();
    int n;
    mem_word = 32'hAABBCCDD;
    issue(7'b0000100, 4'b0100, 32'h100, 32'h0, 0, n);
    total++;
    if (n !== 3) begin bad++; $display("FAIL mem_byte_busy: got %0d, required 3", n); end
    total++;
    if (rd_data !== 32'h000000BB) begin
      bad++; $display("FAIL mem_byte_data: got %h, required 000000bb", rd_data);
    end
    issue(7'b0000100, 4'b1111, 32'h104, 32'h0, 0, n);
    total++;
    if (rd_data !== 32'hAABBCCDD) begin
      bad++; $display("FAIL mem_word_data: got %h, required aabbccdd", rd_data);
    end
    issue(7'b0000100, 4'b0011, 32'h108, 32'h0, 0, n);
    total++;
    if ({n, err, rd_data, mem_en_cnt} !== {32'd1, 1'b1, 32'hAABBCCDD, 32'd0}) begin
      bad++; $display("FAIL mem_bad_be: got n=%0d err=%b rd=%h en=%0d, required 1 1 aabbccdd 0",
                      n, err, rd_data, mem_en_cnt);
    end
    m_rd = 32'hAABBCCDD; m_err = 1'b1;
  endtask

  task automatic test_rf_x0();
    int n;
    rf_val = 32'hFFFF_0001;
    issue(7'b0000010, 4'h0, 32'h0, 32'h1234, 0, n);
    total++;
    if ({n, rf_we_cnt, err} !== {32'd1, 32'd0, 1'b0}) begin
      bad++; $display("FAIL rf_wr_x0: got n=%0d we_cycles=%0d err=%b, required 1 0 0", n, rf_we_cnt, err);
    end
    issue(7'b0000001, 4'h0, 32'h0, 32'h0, 0, n);
    total++;
    if (rd_data !== 32'h0) begin bad++; $display("FAIL rf_rd_x0: got %h, required 0", rd_data); end
    issue(7'b0000010, 4'h0, 32'h7, 32'h5A5A_0707, 0, n);
    total++;
    if ({rf_we_cnt, rf_we_addr, rf_we_data} !== {32'd1, 5'd7, 32'h5A5A_0707}) begin
      bad++; $display("FAIL rf_wr_x7: got cnt=%0d addr=%0d data=%h, required 1 7 5a5a0707",
                      rf_we_cnt, rf_we_addr, rf_we_data);
    end
    m_rd = 32'h0; m_err = 1'b0;
  endtask

  task automatic test_simultaneous();
    int n;
    issue(7'b1100000, 4'h0, 32'h0, 32'h0, 0, n);
    total++;
    if ({n, pulse_cnt} !== {32'd4, 32'd4}) begin
      bad++; $display("FAIL simul_pulse: got busy=%0d pulse=%0d, required 4 4", n, pulse_cnt);
    end
    total++;
    if ({paused, core_stall} !== {m_paused, m_paused}) begin
      bad++; $display("FAIL simul_paused: got paused=%b stall=%b, required %b", paused, core_stall, m_paused);
    end
  endtask

  task automatic test_mem_while_running();
    int n;
    issue(7'b0010000, 4'h0, 32'h0, 32'h0, 0, n);
    m_paused = 1'b0;
    issue(7'b0000100, 4'hF, 32'h200, 32'h0, 0, n);
    total++;
    if ({n, err, mem_en_cnt, paused} !== {32'd1, 1'b1, 32'd0, 1'b0}) begin
      bad++; $display("FAIL mem_running: got n=%0d err=%b en=%0d paused=%b, required 1 1 0 0",
                      n, err, mem_en_cnt, paused);
    end
    issue(7'b0010000, 4'h0, 32'h0, 32'h0, 0, n);
    total++;
    if ({n, err} !== {32'd1, 1'b0}) begin
      bad++; $display("FAIL err_clear: got n=%0d err=%b, required 1 0", n, err);
    end
    m_err = 1'b0;
  endtask

  task automatic test_mid_reset();
    int n;
    issue(7'b0100000, 4'h0, 32'h0, 32'h0, 0, n);
    {reset, pause, resume, mem_wr, mem_rd, rf_wr, rf_rd} = 7'b0000100;
    mem_be = 4'hF; addr = 32'h300; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (dbg_mem_en !== 1'b1) begin bad++; $display("FAIL midrst_active: got en=%b, required 1", dbg_mem_en); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({mcu_busy, rd_data, paused, err, core_stall, core_reset, dbg_mem_en, dbg_mem_we,
         dbg_mem_be, dbg_mem_addr, dbg_mem_wdata, dbg_rf_en, dbg_rf_we, dbg_rf_addr,
         dbg_rf_wdata} !== 146'd0) begin
      bad++; $display("FAIL midrst_outputs: got busy=%b en=%b paused=%b stall=%b, required all zero",
                      mcu_busy, dbg_mem_en, paused, core_stall);
    end
    m_paused = 1'b0; m_err = 1'b0; m_rd = '0;
    issue(7'b0100000, 4'h0, 32'h0, 32'h0, 2, n);
    m_paused = 1'b1;
    total++;
    if ({n, paused, core_stall} !== {32'd3, 1'b1, 1'b1}) begin
      bad++; $display("FAIL midrst_pause: got n=%0d paused=%b stall=%b, required 3 1 1", n, paused, core_stall);
    end
  endtask

  task automatic test_random();
    logic [3:0] be_tab [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h3, 4'h0, 4'h6};
    for (int it = 0; it < 80; it++) begin
      logic [6:0]  stb;
      logic [3:0]  be;
      logic [31:0] a, wd;
      int idle_delay, n, sel, exp_n, exp_pulse, exp_en, exp_we;
      int r = $urandom_range(0, 9);
      stb = (r < 7) ? 7'(1 << $urandom_range(0, 6)) : (r < 9) ? 7'($urandom) : 7'd0;
      be  = be_tab[$urandom_range(0, 7)];
      a   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      wd  = $urandom;
      idle_delay = $urandom_range(0, 3);
      mem_word = $urandom;
      rf_val   = $urandom;
      sel = -1;
      for (int b = 6; b >= 0; b--) if (stb[b] && sel < 0) sel = b;
      exp_n = 0; exp_pulse = 0; exp_en = 0; exp_we = 0;
      case (sel)
        6: begin exp_n = RST_CYC; exp_pulse = RST_CYC; m_err = 1'b0; end
        5: begin exp_n = m_paused ? 1 : idle_delay + 1; m_paused = 1'b1; m_err = 1'b0; end
        4: begin exp_n = 1; m_paused = 1'b0; m_err = 1'b0; end
        3, 2: begin
          if (m_paused && be_legal(be)) begin
            exp_n = (sel == 2) ? MEM_LAT + 1 : 1;
            exp_en = exp_n;
            if (sel == 2) m_rd = pick_byte(mem_word, be);
            m_err = 1'b0;
          end else begin
            exp_n = 1; m_err = 1'b1;
          end
        end
        1, 0: begin
          exp_n = 1;
          if (m_paused) begin
            m_err = 1'b0;
            if (sel == 0) m_rd = (a[4:0] == 5'd0) ? 32'h0 : rf_val;
            else exp_we = (a[4:0] != 5'd0) ? 1 : 0;
          end else m_err = 1'b1;
        end
        default: ;
      endcase
      issue(stb, be, a, wd, idle_delay, n);
      total++;
      if (n !== exp_n) begin
        bad++; $display("FAIL rnd_busy[%0d]: stb=%b got %0d, required %0d", it, stb, n, exp_n);
      end
      total++;
      if ({paused, core_stall, err, rd_data} !== {m_paused, m_paused, m_err, m_rd}) begin
        bad++; $display("FAIL rnd_state[%0d]: stb=%b be=%h got p=%b s=%b e=%b rd=%h, required p=%b s=%b e=%b rd=%h",
                        it, stb, be, paused, core_stall, err, rd_data, m_paused, m_paused, m_err, m_rd);
      end
      total++;
      if ({pulse_cnt, mem_en_cnt, rf_we_cnt} !== {exp_pulse, exp_en, exp_we}) begin
        bad++; $display("FAIL rnd_activity[%0d]: stb=%b got pulse=%0d en=%0d we=%0d, required %0d %0d %0d",
                        it, stb, pulse_cnt, mem_en_cnt, rf_we_cnt, exp_pulse, exp_en, exp_we);
      end
      if (exp_we == 1) begin
        total++;
        if ({rf_we_addr, rf_we_data} !== {a[4:0], wd}) begin
          bad++; $display("FAIL rnd_rf_write[%0d]: got addr=%0d data=%h, required %0d %h",
                          it, rf_we_addr, rf_we_data, a[4:0], wd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_strobe();
    test_pause_handshake();
    test_mem_byte_read();
    test_rf_x0();
    test_simultaneous();
    test_mem_while_running();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcu_debug_responder.md
Name: mcu_debug_responder

Overview:
- MCU-side responder for the UART debugger's controller-to-MCU command interface.
- Accepts the pause, resume, reset, register and memory strobes qualified by `in_valid`, and executes each on the core.
- Executes by stalling the core, pulsing its reset, or borrowing its memory and register-file ports.
- Reports completion on `mcu_busy` and returns read data. Sits between the debugger controller and the MCU core.

Parameters:
- MEM_RD_LAT, 2: cycles from memory request to valid `mem_rdata`; range 1-15.
- RESET_CYCLES, 4: width of the `core_reset` pulse; range 1-15.
- WDOG_CYCLES, 1024: pause watchdog limit, used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  command strobes valid this cycle
- pause  in  1  command: pause core
- resume  in  1  command: resume core
- reset  in  1  command: reset core
- rf_rd  in  1  command: read register
- rf_wr  in  1  command: write register
- mem_rd  in  1  command: read memory
- mem_wr  in  1  command: write memory
- mem_be  in  4  byte enables for memory commands
- addr  in  32  memory address; bits [4:0] give the register index
- wdata  in  32  write data
- mcu_busy  out  1  command in progress
- rd_data  out  32  read result
- paused  out  1  core is held by the debugger
- err  out  1  sticky: last command rejected
- core_idle  in  1  core is at an instruction boundary
- core_stall  out  1  freeze core
- core_reset  out  1  reset core
- dbg_mem_en  out  1  memory port override
- dbg_mem_we  out  1  memory write enable
- dbg_mem_be  out  4  memory byte enables
- dbg_mem_addr  out  32  memory address
- dbg_mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- dbg_rf_en  out  1  register-file port override
- dbg_rf_we  out  1  register-file write enable
- dbg_rf_addr  out  5  register index
- dbg_rf_wdata  out  32  register write data
- rf_rdata  in  32  register read data

Behaviour:
- Reset values: all outputs 0; state IDLE.
- `rst` mid-operation aborts the operation, releases `core_stall` and clears `paused`.
- Acceptance: a command is accepted only in IDLE with `in_valid`=1. `in_valid` outside IDLE is ignored.
- On acceptance, `mcu_busy` rises on the next cycle. Strobes and operands are registered at acceptance; later input changes are ignored.
- Completion: `mcu_busy` falls in the cycle where the results (`rd_data`, `paused`, `err`) are already valid. The minimum busy time is 1 cycle.
- Multiple strobes at once: priority is reset > pause > resume > mem_wr > mem_rd > rf_wr > rf_rd. Lower-priority strobes are dropped.
- `in_valid`=1 with no strobe set: no action and no busy.
- State IDLE: dispatches as above.
- State PAUSE_WAIT: holds until `core_idle`=1, then asserts `core_stall`, sets `paused`=1 and returns to IDLE. Pause while already paused takes 1 busy cycle and changes nothing.
- State RESUME: clears `core_stall` and `paused` in 1 busy cycle. Resume while not paused is a 1-cycle no-op.
- State RESET_PULSE: `core_reset`=1 for exactly RESET_CYCLES cycles. The `paused` state is preserved: if paused, `core_stall` stays high.
- State MEM_ACCESS:
  - Legal only when `paused`=1; otherwise the command is rejected.
  - `dbg_mem_en` is held for the whole access; `dbg_mem_we`=1 for 1 cycle on writes.
  - Reads wait MEM_RD_LAT cycles.
  - Byte read (exactly one `mem_be` bit set): `rd_data` = the selected byte, zero-extended to 32 bits.
  - Word read: `rd_data` = `mem_rdata`.
  - Any other `mem_be` pattern is rejected.
- State RF_ACCESS:
  - Legal only when `paused`=1.
  - Takes 1 access cycle.
  - A write to x0 is performed with `dbg_rf_we` forced to 0. A read of x0 returns 0.
- Rejection: 1 busy cycle, `err`=1, no side effects.
- `err` clears on the next accepted legal command.
- `rd_data` holds its value until the next read completes.

Optional Feature:
- Macro: DBG_RESP_WATCHDOG_EN.
- With the macro: a 16-bit counter runs in PAUSE_WAIT. If `core_idle` has not been seen after WDOG_CYCLES cycles, the block forces `core_stall`, sets `paused`=1 and `err`=1, and completes.
- Without the macro: PAUSE_WAIT waits for `core_idle` indefinitely. WDOG_CYCLES is unused.

Decomposition:
- Package `dbg_pkg` holds:
  - the state enum `resp_state_t`;
  - the command-priority encoding `dbg_cmd_t` (NONE, PAUSE, RESUME, RESET, MEM_RD, MEM_WR, RF_RD, RF_WR);
  - the byte-enable constants BE_WORD = 4'b1111 and BE_NONE = 0.
- One sub-module, `dbg_byte_extract`: combinational lane select and zero-extend driven by `mem_be`.
- Everything else stays in one FSM.

Test Plan:
- Pause handshake: `core_idle`=0 for 5 cycles, then 1 -> `mcu_busy` high for 6 cycles; `core_stall`=1 and `paused`=1 when busy falls.
- Memory byte read: while paused, `mem_rd` with `addr`=0x100, `mem_be`=4'b0100, `mem_rdata`=0xAABBCCDD, MEM_RD_LAT=2 -> `rd_data`=0x000000BB; busy for 3 cycles.
- Register write to x0 then read: `rf_wr` to x0 with 0x1234, then `rf_rd` of x0 -> `dbg_rf_we` never asserted; `rd_data`=0.
- Memory read while running: `mem_rd` with `paused`=0 -> busy 1 cycle; `err`=1; `dbg_mem_en` never asserted.
- Simultaneous strobes: `pause` and `reset` together -> `core_reset` high for exactly 4 cycles; `paused` unchanged.
- Mid-operation reset: `rst` during MEM_ACCESS -> all outputs 0 next cycle; a following `pause` completes normally.
